mem_pipe_reg: RTL
=================

// Module: mem_pipe_reg
// PURPOSE
// - MEM-stage pipeline register with valid/allowin handshake. Sits between the EXE stage and WB.
// - Latches EXE results and issues a single data-memory request per instruction.
// - Holds loads for DMEM_LAT cycles and drops its contents on a WB-committed exception or eret flush.
// - Exports bypass and hazard status for the ID-stage forwarding logic.
// PARAMETERS
// - DMEM_LAT  1  cycles a load occupies MEM before its data is valid (>=1)
// PORTS
// - clk               in   1   clock, rising edge
// - rst               in   1   synchronous active-high reset
// - exe_to_mem_valid  in   1   EXE holds a valid instruction for MEM
// - wb_allowin        in   1   WB can accept an instruction this cycle
// - flush             in   1   exception/eret committed in WB; kill MEM contents
// - pc_in/alu_res_in/rt_in      in  32  instruction PC, ALU result/address, store data
// - rdc_in/cp0_rdc_in/ex_code_in  in  5  GPR dest, CP0 reg, exception code
// - rd_mux_sel_in     in   2   WB result select
// - dmem_we_in/rf_we_in/lw_instr_in/mfc0_instr_in/ex_in/cp0_we_in/eret_flush_in/branch_delay_in  in 1  control bits
// - mem_allowin       out  1   MEM accepts from EXE this cycle
// - mem_to_wb_valid   out  1   MEM offers a valid instruction to WB
// - pc/alu_res/rt     out  32  registered copies
// - rdc/cp0_rdc/ex_code  out  5  registered copies
// - rd_mux_sel        out  2   registered copy
// - rf_we/lw_instr/mfc0_instr/ex/cp0_we/eret_flush/branch_delay  out 1  registered copies
// - dmem_req          out  1   data-memory access strobe (one pulse per instruction)
// - dmem_wr           out  1   write qualifier for dmem_req
// - mem_bypass_valid  out  1   rdc/alu_res usable as forward source
// - mem_load_block    out  1   MEM holds lw/mfc0; ID must stall on a rdc match
// BEHAVIOUR
// - Reset: all outputs, valid flag, wait counter and req_done are 0.
// - ready_go = !lw_instr || (wait_cnt == DMEM_LAT-1).
// - mem_allowin = !mem_valid || (ready_go && wb_allowin). Combinational.
// - mem_to_wb_valid = mem_valid && ready_go && !flush.
// - Clock edge, priority order:
//   - rst, then flush: mem_valid<=0, wait_cnt<=0, req_done<=0.
//   - Otherwise, when mem_allowin: mem_valid<=exe_to_mem_valid.
//     - If exe_to_mem_valid, latch all *_in fields, wait_cnt<=0, req_done<=0.
//     - Fields are unchanged when not loading.
//   - Otherwise, when mem_valid: wait_cnt increments if lw_instr && wait_cnt<DMEM_LAT-1.
//     - Counter saturates.
//     - req_done<=1 once dmem_req has fired.
// - dmem_req = mem_valid && !req_done && !ex && !eret_flush && !flush && (lw_instr||dmem_we).
//   - A store stalled by wb_allowin=0 never re-issues.
//   - An excepting instruction never touches memory.
// - dmem_wr = dmem_req && dmem_we.
// - Latency: non-load MEM->WB in 1 cycle when wb_allowin; load occupies MEM DMEM_LAT cycles minimum.
// - mem_bypass_valid = mem_valid && rf_we && rdc!=0 && !lw_instr && !mfc0_instr.
// - mem_load_block = mem_valid && rf_we && (lw_instr||mfc0_instr).
// - Simultaneous flush and exe_to_mem_valid: flush wins; the incoming instruction is dropped.
//   - EXE is flushed by the same signal.
// - rst mid-load: counter cleared; no further dmem_req.
// TESTING
// - Reset, then ALU op pc=0x100 rf_we=1 rdc=3 with wb_allowin=1:
//   - mem_to_wb_valid=1 next cycle, mem_bypass_valid=1, dmem_req=0.
// - DMEM_LAT=3, lw at 0x200:
//   - dmem_req pulses once; mem_to_wb_valid rises on the 3rd MEM cycle.
//   - mem_allowin=0 for the first 2 cycles; mem_load_block=1 throughout.
// - sw with wb_allowin held 0 for 4 cycles -> exactly 1 dmem_req/dmem_wr pulse; instruction held, then passes.
// - ex_in=1 store enters -> dmem_req never asserts; ex/ex_code=0x05 propagate to WB.
// - flush asserted with lw mid-wait and exe_to_mem_valid=1 -> next cycle mem_valid=0, mem_to_wb_valid=0, no dmem_req.
// - Back-to-back ALU ops with wb_allowin=1 -> one instruction per cycle; fields match inputs delayed by 1.

Source files
------------

// File: rtl/mem_pipe_reg.sv
// MEM-stage pipeline register between EXE and WB.
// Latches EXE results behind a valid/allowin handshake and issues one data-memory
// request per instruction. Loads stay in MEM for DMEM_LAT cycles. A flush committed
// in WB kills the held instruction. The block also exports forwarding and
// load-use hazard status to ID.
module mem_pipe_reg #(
    parameter int DMEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_to_mem_valid,
    input  logic        wb_allowin,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] rt_in,
    input  logic [4:0]  rdc_in,
    input  logic [4:0]  cp0_rdc_in,
    input  logic [4:0]  ex_code_in,
    input  logic [1:0]  rd_mux_sel_in,
    input  logic        dmem_we_in,
    input  logic        rf_we_in,
    input  logic        lw_instr_in,
    input  logic        mfc0_instr_in,
    input  logic        ex_in,
    input  logic        cp0_we_in,
    input  logic        eret_flush_in,
    input  logic        branch_delay_in,
    output logic        mem_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] pc,
    output logic [31:0] alu_res,
    output logic [31:0] rt,
    output logic [4:0]  rdc,
    output logic [4:0]  cp0_rdc,
    output logic [4:0]  ex_code,
    output logic [1:0]  rd_mux_sel,
    output logic        rf_we,
    output logic        lw_instr,
    output logic        mfc0_instr,
    output logic        ex,
    output logic        cp0_we,
    output logic        eret_flush,
    output logic        branch_delay,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic        mem_bypass_valid,
    output logic        mem_load_block
);

    // The counter only needs to reach DMEM_LAT-1. Keep at least one bit so the
    // design stays legal when DMEM_LAT is 1.
    localparam int CNT_W = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             mem_valid_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             req_done_r;
    logic             dmem_we_r;
    logic             ready_go_s;

    // Handshake, memory strobe and hazard status, derived from the held instruction.
    always_comb begin
        ready_go_s       = 1'b1;
        mem_allowin      = 1'b0;
        mem_to_wb_valid  = 1'b0;
        dmem_req         = 1'b0;
        dmem_wr          = 1'b0;
        mem_bypass_valid = 1'b0;
        mem_load_block   = 1'b0;
        if (lw_instr) begin
            ready_go_s = (wait_cnt_r == CNT_LAST);
        end else begin
            ready_go_s = 1'b1;
        end
        mem_allowin     = !mem_valid_r || (ready_go_s && wb_allowin);
        mem_to_wb_valid = mem_valid_r && ready_go_s && !flush;
        // An instruction that is already excepting, or that is being flushed,
        // must not reach memory. req_done_r prevents a stalled access from
        // being issued a second time.
        dmem_req = mem_valid_r && !req_done_r && !ex && !eret_flush && !flush &&
                   (lw_instr || dmem_we_r);
        dmem_wr  = dmem_req && dmem_we_r;
        // A load or mfc0 result is not available until WB, so it cannot be forwarded.
        mem_bypass_valid = mem_valid_r && rf_we && (rdc != 5'd0) && !lw_instr && !mfc0_instr;
        mem_load_block   = mem_valid_r && rf_we && (lw_instr || mfc0_instr);
    end

    // Stage state: valid flag, load wait counter, request-issued flag and latched fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r  <= 1'b0;
            wait_cnt_r   <= CNT_ZERO;
            req_done_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            pc           <= 32'h0000_0000;
            alu_res      <= 32'h0000_0000;
            rt           <= 32'h0000_0000;
            rdc          <= 5'd0;
            cp0_rdc      <= 5'd0;
            ex_code      <= 5'd0;
            rd_mux_sel   <= 2'd0;
            rf_we        <= 1'b0;
            lw_instr     <= 1'b0;
            mfc0_instr   <= 1'b0;
            ex           <= 1'b0;
            cp0_we       <= 1'b0;
            eret_flush   <= 1'b0;
            branch_delay <= 1'b0;
        end else if (flush) begin
            // Flush takes priority over an incoming instruction. EXE is killed
            // by the same signal, so dropping the incoming instruction is correct.
            mem_valid_r <= 1'b0;
            wait_cnt_r  <= CNT_ZERO;
            req_done_r  <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid_r <= exe_to_mem_valid;
            if (exe_to_mem_valid) begin
                wait_cnt_r   <= CNT_ZERO;
                req_done_r   <= 1'b0;
                dmem_we_r    <= dmem_we_in;
                pc           <= pc_in;
                alu_res      <= alu_res_in;
                rt           <= rt_in;
                rdc          <= rdc_in;
                cp0_rdc      <= cp0_rdc_in;
                ex_code      <= ex_code_in;
                rd_mux_sel   <= rd_mux_sel_in;
                rf_we        <= rf_we_in;
                lw_instr     <= lw_instr_in;
                mfc0_instr   <= mfc0_instr_in;
                ex           <= ex_in;
                cp0_we       <= cp0_we_in;
                eret_flush   <= eret_flush_in;
                branch_delay <= branch_delay_in;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else if (mem_valid_r) begin
            // Stalled in MEM: age the load and record that the access was issued.
            if (lw_instr && (wait_cnt_r != CNT_LAST)) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (dmem_req) begin
                req_done_r <= 1'b1;
            end else begin
                req_done_r <= req_done_r;
            end
        end else begin
            mem_valid_r <= mem_valid_r;
        end
    end

endmodule
